// File: rtl/tristate_io_bank.sv
// tristate_io_bank
//   Bank of WIDTH tristate channels sitting between user logic and the
//   OBUFT/IOBUF primitives. Each channel runs a small direction FSM that holds
//   the pad in Hi-Z for TURNAROUND cycles before driving, so the far end has
//   time to let go of the line. Release is immediate. An optional open-drain
//   mode only ever pulls low. Pad readback is synchronised. A sticky per-channel
//   error flags a driven value that the pad does not show once the readback
//   has had time to settle.
//
//   Ports
//     clk          clock, rising edge
//     rst          synchronous active-high reset
//     dir_req      per channel: 1 = request drive, 0 = release to Hi-Z
//     out_data     per channel data to drive
//     err_clr      per channel clear of the sticky drive_err bit
//     pad_i        pad readback (IOBUF O)
//     pad_o        primitive I input
//     pad_t        primitive T input, 1 = Hi-Z
//     in_data      pad_i after SYNC_STAGES flops
//     drive_active channel is in DRIVE
//     busy         channel is in WAIT (turnaround)
//     drive_err    sticky: driven value not seen on the pad
//
//   state | meaning
//   IDLE  | pad released (Hi-Z), waiting for dir_req
//   WAIT  | drive requested, pad still Hi-Z while cnt runs down
//   DRIVE | pad driven from out_data
module tristate_io_bank #(
   parameter int WIDTH       = 4,
   parameter int TURNAROUND  = 2,
   parameter int SYNC_STAGES = 2,
   parameter int OPEN_DRAIN  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dir_req,
   input  logic [WIDTH-1:0] out_data,
   input  logic [WIDTH-1:0] err_clr,
   input  logic [WIDTH-1:0] pad_i,
   output logic [WIDTH-1:0] pad_o,
   output logic [WIDTH-1:0] pad_t,
   output logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] drive_active,
   output logic [WIDTH-1:0] busy,
   output logic [WIDTH-1:0] drive_err
);

   // A zero turnaround still needs a legal (unused) counter width.
   localparam int CNT_W    = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
   localparam int STAB_MAX = SYNC_STAGES + 1;
   localparam int STAB_W   = $clog2(STAB_MAX + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t           state_q [WIDTH];
   state_t           state_d [WIDTH];
   logic [CNT_W-1:0] cnt_q   [WIDTH];
   logic [CNT_W-1:0] cnt_d   [WIDTH];

   logic [WIDTH-1:0] next_drive;
   logic [WIDTH-1:0] next_wait;
   logic [WIDTH-1:0] pad_o_nxt;
   logic [WIDTH-1:0] pad_t_nxt;
   logic [WIDTH-1:0] exp_val;
   logic [WIDTH-1:0] err_set;

   logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
   logic [STAB_W-1:0] stab_q [WIDTH];

   // ---------------- direction FSMs ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            IDLE: begin
               if (dir_req[i]) begin
                  if (TURNAROUND == 0) begin
                     state_d[i] = DRIVE;
                  end else begin
                     state_d[i] = WAIT;
                     cnt_d[i]   = CNT_W'(TURNAROUND);
                  end
               end
            end
            WAIT: begin
               if (!dir_req[i]) begin
                  state_d[i] = IDLE;
               end else if (cnt_q[i] == CNT_W'(1)) begin
                  state_d[i] = DRIVE;
               end else begin
                  cnt_d[i] = cnt_q[i] - CNT_W'(1);
               end
            end
            DRIVE: begin
               if (!dir_req[i]) begin
                  state_d[i] = IDLE;
               end
            end
            default: state_d[i] = IDLE;
         endcase
      end
   end

   // ---------------- registered pad controls ----------------
   always_comb begin
      next_drive = '0;
      next_wait  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         next_drive[i] = (state_d[i] == DRIVE);
         next_wait[i]  = (state_d[i] == WAIT);
      end
      if (OPEN_DRAIN != 0) begin
         // A '1' in open-drain is expressed by releasing the line.
         pad_o_nxt = '0;
         pad_t_nxt = ~next_drive | out_data;
         exp_val   = '0;
      end else begin
         pad_o_nxt = out_data;
         pad_t_nxt = ~next_drive;
         exp_val   = pad_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pad_o        <= '0;
         pad_t        <= '1;
         drive_active <= '0;
         busy         <= '0;
      end else begin
         pad_o        <= pad_o_nxt;
         pad_t        <= pad_t_nxt;
         drive_active <= next_drive;
         busy         <= next_wait;
      end
   end

   // ---------------- readback synchroniser ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= pad_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign in_data = sync_q[SYNC_STAGES-1];

   // ---------------- drive error detection ----------------
   // The stability count only saturates once the driven value has been
   // held long enough to have crossed the whole synchroniser, so a
   // mismatch at saturation is a real conflict on the pad.
   always_comb begin
      err_set = '0;
      for (int i = 0; i < WIDTH; i++) begin
         err_set[i] = (stab_q[i] == STAB_W'(STAB_MAX)) && !pad_t[i] &&
                      (in_data[i] != exp_val[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            stab_q[i] <= '0;
         end
         drive_err <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (pad_t[i] || (pad_o_nxt[i] != pad_o[i])) begin
               stab_q[i] <= '0;
            end else if (stab_q[i] != STAB_W'(STAB_MAX)) begin
               stab_q[i] <= stab_q[i] + STAB_W'(1);
            end
         end
         // A set on the same edge as a clear must not be lost.
         drive_err <= err_set | (drive_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_tristate_io_bank.sv
module tb_tristate_io_bank;

   localparam int S_PAD_T   = 0;
   localparam int S_PAD_O   = 1;
   localparam int S_IN      = 2;
   localparam int S_DRV     = 3;
   localparam int S_BUSY    = 4;
   localparam int S_ERR     = 5;
   localparam int S_OD_T    = 10;
   localparam int S_OD_O    = 11;
   localparam int S_OD_PAD  = 12;

   typedef struct {
      int         cyc;
      int         sig;
      logic [1:0] exp;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dir_req, out_data, err_clr;
   logic [1:0] pad_i, pad_o, pad_t, in_data, drive_active, busy, drive_err;
   logic [1:0] pad_i_od, pad_o_od, pad_t_od, in_data_od, drive_active_od, busy_od, drive_err_od;
   logic [1:0] force_en, force_val;
   logic [1:0] pad_pp, pad_od;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Push-pull pads sit on a weak pull-down so readback of a driven '1' is
   // distinguishable from an idle line; open-drain pads use a pull-up.
   assign pad_pp   = ~pad_t & pad_o;
   assign pad_i    = (force_en & force_val) | (~force_en & pad_pp);
   assign pad_od   = pad_t_od | pad_o_od;
   assign pad_i_od = pad_od;

   tristate_io_bank #(.WIDTH(2), .TURNAROUND(2), .SYNC_STAGES(2), .OPEN_DRAIN(0)) dut (
      .clk(clk), .rst(rst), .dir_req(dir_req), .out_data(out_data), .err_clr(err_clr),
      .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t), .in_data(in_data),
      .drive_active(drive_active), .busy(busy), .drive_err(drive_err));

   tristate_io_bank #(.WIDTH(2), .TURNAROUND(2), .SYNC_STAGES(2), .OPEN_DRAIN(1)) dut_od (
      .clk(clk), .rst(rst), .dir_req(dir_req), .out_data(out_data), .err_clr(err_clr),
      .pad_i(pad_i_od), .pad_o(pad_o_od), .pad_t(pad_t_od), .in_data(in_data_od),
      .drive_active(drive_active_od), .busy(busy_od), .drive_err(drive_err_od));

   function automatic logic [1:0] get_sig(int s);
      case (s)
         S_PAD_T:  return pad_t;
         S_PAD_O:  return pad_o;
         S_IN:     return in_data;
         S_DRV:    return drive_active;
         S_BUSY:   return busy;
         S_ERR:    return drive_err;
         S_OD_T:   return pad_t_od;
         S_OD_O:   return pad_o_od;
         S_OD_PAD: return pad_od;
         default:  return 2'bxx;
      endcase
   endfunction

   // Expected value of a signal as seen after edge (cyc + edges).
   task automatic chk(input int edges, input int sig, input logic [1:0] v, input string name);
      exp_t e;
      e.cyc  = cyc + edges;
      e.sig  = sig;
      e.exp  = v;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: samples mid-cycle and retires every expectation due now.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            logic [1:0] got;
            got = get_sig(sb[i].sig);
            n_checks++;
            if (sb[i].cyc < cyc) begin
               n_errors++;
               $display("FAIL %s: expectation for edge %0d missed (now %0d)", sb[i].name, sb[i].cyc, cyc);
            end else if (got !== sb[i].exp) begin
               n_errors++;
               $display("FAIL %s @edge %0d: got %b expected %b", sb[i].name, cyc, got, sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      rst = 1'b1; dir_req = 2'b11; out_data = 2'b00; err_clr = 2'b00;
      force_en = 2'b00; force_val = 2'b00;

      // reset held with requests pending
      tick(3);
      chk(0, S_PAD_T, 2'b11, "rst_pad_t");
      chk(0, S_DRV,   2'b00, "rst_drive_active");
      chk(0, S_BUSY,  2'b00, "rst_busy");
      chk(0, S_ERR,   2'b00, "rst_drive_err");
      chk(0, S_IN,    2'b00, "rst_in_data");
      chk(0, S_PAD_O, 2'b00, "rst_pad_o");
      chk(0, S_OD_T,  2'b11, "rst_od_pad_t");
      rst = 1'b0; dir_req = 2'b00;
      tick(3);

      // turnaround on channel 0
      out_data = 2'b01; dir_req = 2'b01;
      chk(1, S_BUSY,  2'b01, "ta_busy_k");
      chk(1, S_PAD_T, 2'b11, "ta_hiz_k");
      chk(2, S_BUSY,  2'b01, "ta_busy_k1");
      chk(2, S_PAD_T, 2'b11, "ta_hiz_k1");
      chk(3, S_PAD_T, 2'b10, "ta_drive_pad_t");
      chk(3, S_PAD_O, 2'b01, "ta_drive_pad_o");
      chk(3, S_DRV,   2'b01, "ta_drive_active");
      chk(3, S_BUSY,  2'b00, "ta_busy_done");
      chk(4, S_IN,    2'b00, "ta_in_data_k3");
      chk(5, S_IN,    2'b01, "ta_in_data_k4");
      tick(8);
      chk(0, S_ERR,   2'b00, "pp_no_err");

      // release from DRIVE
      dir_req = 2'b00;
      chk(1, S_PAD_T, 2'b11, "rel_pad_t");
      chk(1, S_DRV,   2'b00, "rel_drive_active");
      tick(2);

      // one-cycle request pulse aborts in WAIT
      dir_req = 2'b01;
      chk(1, S_BUSY,  2'b01, "abort_busy");
      chk(1, S_PAD_T, 2'b11, "abort_pad_t0");
      tick(1);
      dir_req = 2'b00;
      chk(1, S_PAD_T, 2'b11, "abort_pad_t1");
      chk(1, S_BUSY,  2'b00, "abort_idle");
      chk(2, S_PAD_T, 2'b11, "abort_pad_t2");
      chk(2, S_DRV,   2'b00, "abort_no_drive");
      tick(3);

      // open-drain: data 0,1,0 while in DRIVE
      out_data = 2'b00; dir_req = 2'b01;
      tick(3);
      chk(0, S_OD_T,   2'b10, "od_enter");
      chk(1, S_OD_T,   2'b10, "od_t_0a");
      chk(1, S_OD_PAD, 2'b10, "od_pad_0a");
      tick(1);
      out_data = 2'b01;
      chk(1, S_OD_T,   2'b11, "od_t_1");
      chk(1, S_OD_PAD, 2'b11, "od_pad_1");
      chk(1, S_OD_O,   2'b00, "od_pad_o_1");
      tick(1);
      out_data = 2'b00;
      chk(1, S_OD_T,   2'b10, "od_t_0b");
      chk(1, S_OD_PAD, 2'b10, "od_pad_0b");
      chk(1, S_OD_O,   2'b00, "od_pad_o_0b");
      tick(2);
      dir_req = 2'b00;
      tick(3);

      // contention on channel 1
      force_en = 2'b10; force_val = 2'b00;
      out_data = 2'b10; dir_req = 2'b10;
      chk(3, S_DRV, 2'b10, "ct_drive");
      chk(6, S_ERR, 2'b00, "ct_err_early");
      chk(7, S_ERR, 2'b10, "ct_err_set");
      tick(10);
      chk(0, S_ERR, 2'b10, "ct_err_sticky");
      err_clr = 2'b10;
      chk(1, S_ERR, 2'b10, "ct_collision");
      tick(1);
      err_clr = 2'b00; force_en = 2'b00;
      tick(4);
      err_clr = 2'b10;
      chk(1, S_ERR, 2'b00, "ct_clear");
      tick(1);
      err_clr = 2'b00;
      chk(1, S_ERR, 2'b00, "ct_stay_clear");
      dir_req = 2'b00;
      tick(3);

      // reset mid-WAIT, then full turnaround, then reset mid-DRIVE
      dir_req = 2'b11; out_data = 2'b11;
      chk(1, S_BUSY, 2'b11, "r6_wait");
      tick(1);
      rst = 1'b1;
      chk(1, S_PAD_T, 2'b11, "r6_wait_rst_pad_t");
      chk(1, S_BUSY,  2'b00, "r6_wait_rst_busy");
      chk(1, S_DRV,   2'b00, "r6_wait_rst_drv");
      tick(1);
      rst = 1'b0;
      chk(1, S_BUSY,  2'b11, "r6_new_busy_k");
      chk(2, S_BUSY,  2'b11, "r6_new_busy_k1");
      chk(2, S_PAD_T, 2'b11, "r6_new_hiz_k1");
      chk(3, S_PAD_T, 2'b00, "r6_new_drive");
      chk(3, S_DRV,   2'b11, "r6_new_drive_active");
      tick(4);
      rst = 1'b1;
      chk(1, S_PAD_T, 2'b11, "r6_drive_rst_pad_t");
      chk(1, S_DRV,   2'b00, "r6_drive_rst_drv");
      chk(1, S_PAD_O, 2'b00, "r6_drive_rst_pad_o");
      tick(1);
      rst = 1'b0; dir_req = 2'b00;
      tick(3);

      while (sb.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: never checked (due edge %0d)", sb[0].name, sb[0].cyc);
         void'(sb.pop_front());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
